// File: rtl/grid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : grid_pkg
// Description : Shared types, Q8 angle tables, default colours and helpers
//               for the polar radar grid overlay pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package grid_pkg;

  typedef logic [23:0] color_t;

  localparam int ANGLE_STEPS = 36;  // 5 degree steps over 0..175 degrees
  localparam int ANGLE_W     = 6;

  // cos/sin of (5*i) degrees scaled by 256 and rounded to nearest
  localparam logic signed [31:0] COS_TABLE [ANGLE_STEPS] = '{
     256,  255,  252,  247,  241,  232,  222,  210,  196,
     181,  165,  147,  128,  108,   88,   66,   44,   22,
       0,  -22,  -44,  -66,  -88, -108, -128, -147, -165,
    -181, -196, -210, -222, -232, -241, -247, -252, -255
  };

  localparam logic signed [31:0] SIN_TABLE [ANGLE_STEPS] = '{
       0,   22,   44,   66,   88,  108,  128,  147,  165,
     181,  196,  210,  222,  232,  241,  247,  252,  255,
     256,  255,  252,  247,  241,  232,  222,  210,  196,
     181,  165,  147,  128,  108,   88,   66,   44,   22
  };

  localparam color_t DEF_BLANK_COLOR = 24'h000000;
  localparam color_t DEF_GRID_COLOR  = 24'hFF0000;
  localparam color_t DEF_SWEEP_COLOR = 24'h00FF00;

  // Ping-pong direction of the sweep line
  typedef enum logic [0:0] {
    SWEEP_UP   = 1'b0,
    SWEEP_DOWN = 1'b1
  } sweep_state_e;

  function automatic logic signed [31:0] abs32(input logic signed [31:0] v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic signed [31:0] cos_q8(input int unsigned idx);
    logic [ANGLE_W-1:0] i6;
    i6 = ANGLE_W'(idx % ANGLE_STEPS);
    return COS_TABLE[i6];
  endfunction

  function automatic logic signed [31:0] sin_q8(input int unsigned idx);
    logic [ANGLE_W-1:0] i6;
    i6 = ANGLE_W'(idx % ANGLE_STEPS);
    return SIN_TABLE[i6];
  endfunction

endpackage
`default_nettype wire

// File: rtl/grid_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : grid_sweep_ctrl
// Description : Frame counter and ping-pong FSM stepping the sweep angle
//               0..35..0 once every SWEEP_FRAMES frame strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module grid_sweep_ctrl
  import grid_pkg::*;
#(
  parameter int SWEEP_FRAMES = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               frame_start,
  output logic [ANGLE_W-1:0] sweep_angle
);

  localparam int CNT_W = (SWEEP_FRAMES > 1) ? $clog2(SWEEP_FRAMES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SWEEP_FRAMES - 1);
  localparam logic [ANGLE_W-1:0] ANGLE_MAX = ANGLE_W'(ANGLE_STEPS - 1);

  sweep_state_e       state_q, state_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [ANGLE_W-1:0] angle_q, angle_d;

  // Count frames; on wrap step the angle and flip direction at the end stops
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    angle_d     = angle_q;
    if (frame_start) begin
      if (frame_cnt_q == CNT_LAST) begin
        frame_cnt_d = '0;
        case (state_q)
          SWEEP_UP: begin
            angle_d = angle_q + 1'b1;
            if (angle_d == ANGLE_MAX) state_d = SWEEP_DOWN;
          end
          SWEEP_DOWN: begin
            angle_d = angle_q - 1'b1;
            if (angle_d == '0) state_d = SWEEP_UP;
          end
          default: state_d = SWEEP_UP;
        endcase
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Controller state register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= SWEEP_UP;
      frame_cnt_q <= '0;
      angle_q     <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      angle_q     <= angle_d;
    end
  end

  assign sweep_angle = angle_q;

endmodule
`default_nettype wire

// File: rtl/polar_grid_pipe.sv
`default_nettype none
// ============================================================================
// Module      : polar_grid_pipe
// Description : 3-stage pipelined polar grid renderer (range rings, spokes,
//               display border). Optional rotating sweep line is built when
//               the macro GRID_SWEEP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module polar_grid_pipe
  import grid_pkg::*;
#(
  parameter int     RING_COUNT    = 7,
  parameter int     RING_SPACING  = 32,
  parameter int     SPOKE_COUNT   = 6,
  parameter int     LINE_WIDTH    = 1,
  parameter int     LEFT_BORDER   = -128,
  parameter int     RIGHT_BORDER  = 128,
  parameter int     BOTTOM_BORDER = 128,
  parameter int     TOP_BORDER    = 640,
  parameter int     BORDER_WIDTH  = 3,
  parameter color_t BLANK_COLOR   = DEF_BLANK_COLOR,
  parameter color_t GRID_COLOR    = DEF_GRID_COLOR,
  parameter color_t SWEEP_COLOR   = DEF_SWEEP_COLOR,
  parameter int     SWEEP_FRAMES  = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               frame_start,
  input  logic               in_valid,
  input  logic signed [11:0] x_value,
  input  logic signed [11:0] y_value,
  output logic               out_valid,
  output color_t             pixel,
  output logic [ANGLE_W-1:0] sweep_angle
);

  localparam int LINE_TOL    = LINE_WIDTH * 256;
  localparam int SWEEP_LIMIT = (RING_COUNT * RING_SPACING) * (RING_COUNT * RING_SPACING);

  // Spokes are spread evenly over 0..180 degrees, offset by half a pitch
  function automatic int unsigned spoke_idx(input int j);
    return int'(unsigned'((2 * j + 1) * (ANGLE_STEPS / 2) / SPOKE_COUNT));
  endfunction

  // ---------------- Stage 1: coordinates and products ----------------
  logic               s1_valid_q;
  logic signed [31:0] ye;
  logic signed [31:0] x_q, x_d, y_q, y_d;
  logic signed [31:0] d2_q, d2_d;
  logic signed [31:0] spoke_cross_q [SPOKE_COUNT];
  logic signed [31:0] spoke_cross_d [SPOKE_COUNT];
  logic signed [31:0] spoke_dot_q   [SPOKE_COUNT];
  logic signed [31:0] spoke_dot_d   [SPOKE_COUNT];

  // Sign-extend inputs, shift y to the radar origin, form distance and spoke products
  always_comb begin
    x_d  = {{20{x_value[11]}}, x_value};
    y_d  = {{20{y_value[11]}}, y_value};
    ye   = y_d - BOTTOM_BORDER;
    d2_d = x_d * x_d + ye * ye;
    for (int j = 0; j < SPOKE_COUNT; j++) begin
      spoke_cross_d[j] = x_d * sin_q8(spoke_idx(j)) - ye * cos_q8(spoke_idx(j));
      spoke_dot_d[j]   = x_d * cos_q8(spoke_idx(j)) + ye * sin_q8(spoke_idx(j));
    end
  end

  // Stage 1 datapath register (no reset; qualified by the valid chain)
  always_ff @(posedge clock) begin
    x_q  <= x_d;
    y_q  <= y_d;
    d2_q <= d2_d;
    for (int j = 0; j < SPOKE_COUNT; j++) begin
      spoke_cross_q[j] <= spoke_cross_d[j];
      spoke_dot_q[j]   <= spoke_dot_d[j];
    end
  end

`ifdef GRID_SWEEP_EN
  logic [ANGLE_W-1:0] sweep_angle_w;
  logic signed [31:0] sweep_cross_q, sweep_cross_d;
  logic signed [31:0] sweep_dot_q, sweep_dot_d;

  grid_sweep_ctrl #(
    .SWEEP_FRAMES (SWEEP_FRAMES)
  ) u_sweep_ctrl (
    .clock       (clock),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .sweep_angle (sweep_angle_w)
  );

  assign sweep_angle = sweep_angle_w;

  // Sweep line products use the angle as registered before this edge
  always_comb begin
    sweep_cross_d = x_d * SIN_TABLE[sweep_angle_w] - ye * COS_TABLE[sweep_angle_w];
    sweep_dot_d   = x_d * COS_TABLE[sweep_angle_w] + ye * SIN_TABLE[sweep_angle_w];
  end

  // Stage 1 sweep product register
  always_ff @(posedge clock) begin
    sweep_cross_q <= sweep_cross_d;
    sweep_dot_q   <= sweep_dot_d;
  end
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
  assign sweep_angle        = '0;
`endif

  // ---------------- Stage 2: geometry flags ----------------
  logic s2_valid_q;
  logic out_border_q, out_border_d;
  logic on_border_q, on_border_d;
  logic ring_hit_q, ring_hit_d;
  logic spoke_hit_q, spoke_hit_d;

  // Border box, ring tolerance band and spoke half-plane tests
  always_comb begin
    out_border_d = (x_q > RIGHT_BORDER + BORDER_WIDTH) || (x_q < LEFT_BORDER - BORDER_WIDTH) ||
                   (y_q > TOP_BORDER + BORDER_WIDTH)   || (y_q < BOTTOM_BORDER - BORDER_WIDTH);
    on_border_d  = !out_border_d &&
                   ((x_q > RIGHT_BORDER) || (x_q < LEFT_BORDER) ||
                    (y_q > TOP_BORDER)   || (y_q < BOTTOM_BORDER));
    ring_hit_d = 1'b0;
    for (int k = 1; k <= RING_COUNT; k++) begin
      if (abs32(d2_q - (k * RING_SPACING) * (k * RING_SPACING)) <= 2 * LINE_WIDTH * k * RING_SPACING)
        ring_hit_d = 1'b1;
    end
    spoke_hit_d = 1'b0;
    for (int j = 0; j < SPOKE_COUNT; j++) begin
      if ((abs32(spoke_cross_q[j]) <= LINE_TOL) && (spoke_dot_q[j] >= 0))
        spoke_hit_d = 1'b1;
    end
  end

  // Stage 2 flag register
  always_ff @(posedge clock) begin
    out_border_q <= out_border_d;
    on_border_q  <= on_border_d;
    ring_hit_q   <= ring_hit_d;
    spoke_hit_q  <= spoke_hit_d;
  end

`ifdef GRID_SWEEP_EN
  logic sweep_hit_q, sweep_hit_d;

  // Sweep line is a spoke clipped to the outermost ring
  always_comb begin
    sweep_hit_d = (abs32(sweep_cross_q) <= LINE_TOL) && (sweep_dot_q >= 0) &&
                  (d2_q <= SWEEP_LIMIT);
  end

  // Stage 2 sweep flag register
  always_ff @(posedge clock) begin
    sweep_hit_q <= sweep_hit_d;
  end
`endif

  // ---------------- Stage 3: colour ----------------
  logic   out_valid_q;
  color_t pixel_q, pixel_d;

  // Priority colour select; hold the last colour when no pixel arrives
  always_comb begin
    pixel_d = pixel_q;
    if (s2_valid_q) begin
      if (out_border_q)
        pixel_d = BLANK_COLOR;
`ifdef GRID_SWEEP_EN
      else if (sweep_hit_q)
        pixel_d = SWEEP_COLOR;
`endif
      else if (on_border_q || ring_hit_q || spoke_hit_q)
        pixel_d = GRID_COLOR;
      else
        pixel_d = BLANK_COLOR;
    end
  end

  // Valid chain and output colour; reset drops every in-flight pixel
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      pixel_q     <= BLANK_COLOR;
    end else begin
      s1_valid_q  <= in_valid;
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s2_valid_q;
      pixel_q     <= pixel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign pixel     = pixel_q;

endmodule
`default_nettype wire

// File: tb/tb_polar_grid_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_polar_grid_pipe
// Description : Self-checking bench for polar_grid_pipe (directed vectors,
//               latency/streaming/reset checks, sweep ping-pong when the
//               GRID_SWEEP_EN macro is defined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_polar_grid_pipe;
  import grid_pkg::*;

  logic               clock = 1'b0;
  logic               reset_n;
  logic               frame_start;
  logic               in_valid;
  logic signed [11:0] x_value;
  logic signed [11:0] y_value;
  logic               out_valid;
  color_t             pixel;
  logic [5:0]         sweep_angle;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  polar_grid_pipe #(
    .SWEEP_FRAMES (2)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .in_valid    (in_valid),
    .x_value     (x_value),
    .y_value     (y_value),
    .out_valid   (out_valid),
    .pixel       (pixel),
    .sweep_angle (sweep_angle)
  );

  typedef struct {
    string  name;
    int     x;
    int     y;
    color_t exp_plain;   // no sweep line present
    color_t exp_sweep0;  // sweep line present at angle 0 (along +x)
  } vec_t;

  vec_t vecs [18];

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // One pixel in, exact 3-cycle latency, colour check
  task automatic send(input string name, input int x, input int y, input color_t exp,
                      input logic fs = 1'b0);
    x_value     = 12'(x);
    y_value     = 12'(y);
    in_valid    = 1'b1;
    frame_start = fs;
    tick(1);
    in_valid    = 1'b0;
    frame_start = 1'b0;
    tick(1);
    check({name, "_early"}, 32'(out_valid), 32'd0);
    tick(1);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_pixel"}, 32'(pixel), 32'(exp));
  endtask

  task automatic pulse_frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
      tick(1);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [2:0] mv;
    color_t     stream_exp;

    vecs[0]  = '{"ring1",        32, 128, 24'hFF0000, 24'h00FF00};
    vecs[1]  = '{"axis90",        0, 176, 24'h000000, 24'h000000};
    vecs[2]  = '{"right_in",    129, 300, 24'hFF0000, 24'hFF0000};
    vecs[3]  = '{"right_edge",  131, 300, 24'hFF0000, 24'hFF0000};
    vecs[4]  = '{"right_out",   132, 300, 24'h000000, 24'h000000};
    vecs[5]  = '{"corner_out",  200, 700, 24'h000000, 24'h000000};
    vecs[6]  = '{"spoke45",     100, 228, 24'hFF0000, 24'hFF0000};
    vecs[7]  = '{"spoke135",   -100, 228, 24'hFF0000, 24'hFF0000};
    vecs[8]  = '{"left_bord",  -130, 300, 24'hFF0000, 24'hFF0000};
    vecs[9]  = '{"top_bord",      0, 642, 24'hFF0000, 24'hFF0000};
    vecs[10] = '{"top_out",       0, 644, 24'h000000, 24'h000000};
    vecs[11] = '{"bot_bord",     50, 126, 24'hFF0000, 24'hFF0000};
    vecs[12] = '{"ring3_in",      0, 223, 24'hFF0000, 24'hFF0000};
    vecs[13] = '{"ring3_on",      0, 224, 24'hFF0000, 24'hFF0000};
    vecs[14] = '{"ring3_out",     0, 225, 24'h000000, 24'h000000};
    vecs[15] = '{"quiet",        10, 300, 24'h000000, 24'h000000};
    vecs[16] = '{"spoke15_in",    3, 128, 24'hFF0000, 24'h00FF00};
    vecs[17] = '{"spoke15_out",   5, 128, 24'h000000, 24'h00FF00};

    reset_n     = 1'b0;
    frame_start = 1'b0;
    in_valid    = 1'b0;
    x_value     = '0;
    y_value     = '0;
    tick(2);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_pixel", 32'(pixel), 32'h000000);
    check("reset_sweep_angle", 32'(sweep_angle), 32'd0);
    reset_n = 1'b1;
    tick(1);

    // Static vectors (sweep, if present, sits at angle 0 after reset)
    for (int i = 0; i < 18; i++) begin
`ifdef GRID_SWEEP_EN
      send(vecs[i].name, vecs[i].x, vecs[i].y, vecs[i].exp_sweep0);
`else
      send(vecs[i].name, vecs[i].x, vecs[i].y, vecs[i].exp_plain);
`endif
    end

    // Output holds while no pixel is valid (last vector above)
    tick(3);
    check("hold_valid", 32'(out_valid), 32'd0);
`ifdef GRID_SWEEP_EN
    check("hold_pixel", 32'(pixel), 32'h00FF00);
`else
    check("hold_pixel", 32'(pixel), 32'h000000);
`endif

    // Pixel launched in the same cycle as a frame strobe is processed normally
    send("fs_with_pixel", 131, 300, 24'hFF0000, 1'b1);

    // Streaming with a reset pulse at pixel 50
    stream_exp = 24'hFF0000;
`ifdef GRID_SWEEP_EN
    stream_exp = 24'h00FF00;
    do_reset();  // bring the sweep back to angle 0 for a known colour
    tick(1);
`endif
    mv = 3'b000;
    for (int i = 0; i < 106; i++) begin
      in_valid = (i < 100);
      reset_n  = (i != 50);
      x_value  = 12'sd32;
      y_value  = 12'sd128;
      tick(1);
      mv = reset_n ? {mv[1:0], in_valid} : 3'b000;
      check("stream_valid", 32'(out_valid), 32'(mv[2]));
      if (i >= 50 && i <= 52) check("stream_reset_pixel", 32'(pixel), 32'h000000);
      if (i == 53 || i == 10) check("stream_pixel", 32'(pixel), 32'(stream_exp));
    end
    reset_n  = 1'b1;
    in_valid = 1'b0;
    tick(2);

`ifdef GRID_SWEEP_EN
    // Sweep colour at 90 degrees
    do_reset();
    pulse_frames(1);
    check("sweep_count_no_step", 32'(sweep_angle), 32'd0);
    pulse_frames(35);
    check("sweep_at_18", 32'(sweep_angle), 32'd18);
    send("sweep_hit", 0, 200, 24'h00FF00);
    send("sweep_beyond", 0, 400, 24'h000000);

    // Ping-pong
    do_reset();
    pulse_frames(70);
    check("pingpong_top", 32'(sweep_angle), 32'd35);
    pulse_frames(2);
    check("pingpong_down", 32'(sweep_angle), 32'd34);
    pulse_frames(68);
    check("pingpong_bottom", 32'(sweep_angle), 32'd0);
    pulse_frames(2);
    check("pingpong_up_again", 32'(sweep_angle), 32'd1);
`else
    pulse_frames(10);
    check("no_sweep_angle", 32'(sweep_angle), 32'd0);
    send("no_sweep_pixel", 0, 200, 24'h000000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
